// File: rtl/instr_injector_pkg.sv
// rtl/instr_injector_pkg.sv - request kinds, opcodes, register codes and the word encoder for instr_injector
package instr_injector_pkg;

  typedef enum logic [1:0] {
    REQ_SETREG = 2'd0,
    REQ_RAW    = 2'd1,
    REQ_END    = 2'd2,
    REQ_RSVD   = 2'd3
  } req_kind_e;

  typedef enum logic [4:0] {
    OP_LITL = 5'd0,
    OP_LITH = 5'd1,
    OP_FUNC = 5'd31
  } op_e;

  typedef enum logic [3:0] {
    REG_R = 4'd0,
    REG_S = 4'd1,
    REG_C = 4'd2,
    REG_X = 4'd6
  } reg_e;

  localparam logic [3:0] OPD_DONE   = 4'hF;
  localparam logic [8:0] INSTR_DONE = {OP_FUNC, OPD_DONE};

  function automatic logic [8:0] enc(op_e op, logic [3:0] opd);
    return {op, opd};
  endfunction

endpackage

// File: rtl/instr_injector.sv
// rtl/instr_injector.sv - turns boot/debug requests into 9-bit instruction words for the fetch mux
// Optional build macro LIT_SHORTCUT_EN: SETREG with a zero high nibble skips the LITH word.
module instr_injector
  import instr_injector_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [3:0]       req_dst,
  input  logic [7:0]       req_val,
  input  logic [8:0]       req_raw,
  output logic [8:0]       instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic             err,
  output logic             done,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LIT_LO,
    S_LIT_HI,
    S_MOV,
    S_RAW,
    S_END
  } state_e;

`ifdef LIT_SHORTCUT_EN
  localparam bit SHORTCUT = 1'b1;
`else
  localparam bit SHORTCUT = 1'b0;
`endif

  state_e           r_state;
  logic [8:0]       r_instr;
  logic             r_instr_valid;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_dst;
  logic [3:0]       r_val_hi;

  state_e           w_state_nxt;
  logic [8:0]       w_instr_nxt;
  logic             w_valid_nxt;
  logic             w_err_nxt;
  logic             w_accept;
  logic             w_beat;
  logic             w_skip_hi;
  state_e           w_after_lit_state;
  logic [8:0]       w_after_lit_instr;
  logic             w_after_lit_valid;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_beat    = r_instr_valid && instr_ready;
  assign w_skip_hi = SHORTCUT && (r_val_hi == 4'd0);

  // Once the literal is built, dst=r already holds it; any other dst needs a MOV whose opcode is the dst code.
  always_comb begin
    w_after_lit_state = S_MOV;
    w_after_lit_instr = {1'b0, r_dst, 4'd0};
    w_after_lit_valid = 1'b1;
    if (r_dst == REG_R) begin
      w_after_lit_state = S_IDLE;
      w_after_lit_instr = 9'h000;
      w_after_lit_valid = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_instr_valid;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          case (req_kind_e'(req_kind))
            REQ_SETREG: begin
              if (req_dst == REG_S) begin
                w_err_nxt = 1'b1;
              end else begin
                w_state_nxt = S_LIT_LO;
                w_instr_nxt = enc(OP_LITL, req_val[3:0]);
                w_valid_nxt = 1'b1;
              end
            end
            REQ_RAW: begin
              w_state_nxt = S_RAW;
              w_instr_nxt = req_raw;
              w_valid_nxt = 1'b1;
            end
            REQ_END: begin
              w_state_nxt = S_END;
              w_instr_nxt = INSTR_DONE;
              w_valid_nxt = 1'b1;
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
      end
      S_LIT_LO: begin
        if (w_beat) begin
          if (w_skip_hi) begin
            w_state_nxt = w_after_lit_state;
            w_instr_nxt = w_after_lit_instr;
            w_valid_nxt = w_after_lit_valid;
          end else begin
            w_state_nxt = S_LIT_HI;
            w_instr_nxt = enc(OP_LITH, r_val_hi);
          end
        end
      end
      S_LIT_HI: begin
        if (w_beat) begin
          w_state_nxt = w_after_lit_state;
          w_instr_nxt = w_after_lit_instr;
          w_valid_nxt = w_after_lit_valid;
        end
      end
      default: begin
        if (w_beat) begin
          w_state_nxt = S_IDLE;
          w_instr_nxt = 9'h000;
          w_valid_nxt = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_instr       <= 9'h000;
      r_instr_valid <= 1'b0;
      r_err         <= 1'b0;
      r_cnt         <= '0;
      r_dst         <= 4'd0;
      r_val_hi      <= 4'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_valid_nxt;
      r_err         <= w_err_nxt;
      if (w_beat) r_cnt <= r_cnt + CNT_W'(1);
      if (w_accept) begin
        r_dst    <= req_dst;
        r_val_hi <= req_val[7:4];
      end
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign err         = r_err;
  assign done        = (r_state == S_END) && w_beat;
  assign instr_cnt   = r_cnt;

endmodule

// File: tb/tb_instr_injector.sv
// tb/tb_instr_injector.sv - scoreboard bench for instr_injector (honours LIT_SHORTCUT_EN)
module tb_instr_injector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [3:0]  req_dst;
  logic [7:0]  req_val;
  logic [8:0]  req_raw;
  logic [8:0]  instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        err;
  logic        done;
  logic [15:0] instr_cnt;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          exp_cnt = 0;
  int          err_seen = 0;
  logic [8:0]  sb[$];
  int          beat_cyc[$];

`ifdef LIT_SHORTCUT_EN
  localparam bit SHORTCUT = 1'b1;
`else
  localparam bit SHORTCUT = 1'b0;
`endif

  instr_injector #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_dst    (req_dst),
    .req_val    (req_val),
    .req_raw    (req_raw),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .err        (err),
    .done       (done),
    .instr_cnt  (instr_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: pop and compare on every completed beat, sampled mid-cycle.
  always @(negedge clk) begin
    logic [8:0] e;
    if (err) err_seen++;
    if (err && done) chk("err_done_excl", 32'(done), 32'd0);
    if (instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 32'(instr_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("word", 32'(instr), 32'(e));
        chk("done_on_beat", 32'(done), 32'(e == 9'h1FF));
        exp_cnt++;
        beat_cyc.push_back(cyc);
      end
    end else if (done) begin
      chk("done_spurious", 32'(done), 32'd0);
    end
  end

  task automatic send(input logic [1:0] kind, input logic [3:0] dst, input logic [7:0] val,
                      input logic [8:0] raw);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_kind  = kind;
    req_dst   = dst;
    req_val   = val;
    req_raw   = raw;
    if (kind == 2'd0 && dst != 4'd1) begin
      sb.push_back({5'd0, val[3:0]});
      if (!(SHORTCUT && val[7:4] == 4'd0)) sb.push_back({5'd1, val[7:4]});
      if (dst != 4'd0) sb.push_back({1'b0, dst, 4'd0});
    end else if (kind == 2'd1) begin
      sb.push_back(raw);
    end else if (kind == 2'd2) begin
      sb.push_back(9'h1FF);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_kind = 2'd0; req_dst = 4'd0;
    req_val = 8'd0; req_raw = 9'd0; instr_ready = 1'b1;
    #3;
    chk("rst_instr", 32'(instr), 32'h000);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // 1: SETREG x=A5, back-to-back beats
    beat_cyc.delete();
    send(2'd0, 4'd6, 8'hA5, 9'd0);
    drain();
    chk("t1_cnt", 32'(instr_cnt), 32'(exp_cnt));
    chk("t1_cnt_abs", 32'(instr_cnt), 32'd3);
    chk("t1_nbeats", 32'(beat_cyc.size()), 32'd3);
    if (beat_cyc.size() == 3) chk("t1_consecutive", 32'(beat_cyc[2] - beat_cyc[0]), 32'd2);

    // 2: SETREG r=3C, no MOV
    send(2'd0, 4'd0, 8'h3C, 9'd0);
    drain();
    chk("t2_req_ready", 32'(req_ready), 32'd1);
    chk("t2_cnt", 32'(instr_cnt), 32'(exp_cnt));

    // 3: SETREG s is illegal
    send(2'd0, 4'd1, 8'h55, 9'd0);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_valid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    chk("t3_err_1cyc", 32'(err), 32'd0);
    chk("t3_valid2", 32'(instr_valid), 32'd0);
    chk("t3_cnt", 32'(instr_cnt), 32'(exp_cnt));

    // 4: SETREG c=07 with 5-cycle stall on the 2nd word
    send(2'd0, 4'd2, 8'h07, 9'd0);
    @(posedge clk); #1;
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_word", 32'(instr), SHORTCUT ? 32'h020 : 32'h010);
      chk("t4_hold_valid", 32'(instr_valid), 32'd1);
    end
    instr_ready = 1'b1;
    drain();
    chk("t4_cnt", 32'(instr_cnt), 32'(exp_cnt));

    // 5: RAW then END
    send(2'd1, 4'd0, 8'd0, 9'h123);
    send(2'd2, 4'd0, 8'd0, 9'd0);
    drain();
    chk("t5_cnt", 32'(instr_cnt), 32'(exp_cnt));

    // reserved kind
    send(2'd3, 4'd0, 8'd0, 9'd0);
    chk("rsvd_err", 32'(err), 32'd1);
    chk("rsvd_valid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    chk("err_total", 32'(err_seen), 32'd2);

    // 6: reset during LIT_HI of SETREG x=A5
    send(2'd0, 4'd6, 8'hA5, 9'd0);
    @(posedge clk); #1;
    chk("t6_in_lithi", 32'(instr), 32'h01A);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(instr_valid), 32'd0);
    chk("t6_rst_instr", 32'(instr), 32'h000);
    chk("t6_rst_cnt", 32'(instr_cnt), 32'd0);
    sb.delete();
    exp_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_req_ready", 32'(req_ready), 32'd1);
    send(2'd1, 4'd0, 8'd0, 9'h0AB);
    drain();
    chk("t6_cnt", 32'(instr_cnt), 32'd1);
    chk("t6_model_cnt", 32'(instr_cnt), 32'(exp_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
